sd_cmd_phy: RTL

//  Serial CMD-line engine of the SD host, directly downstream of the CPU register/command-issue block.

---
 rtl/sd_cmd_pkg.sv | 20 ++
 rtl/sd_cmd_phy_if.sv | 20 ++
 rtl/sd_crc7.sv | 15 +
 rtl/sd_cmd_phy.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_pkg.sv
// Shared constants, state encoding and the CRC7 step used by the SD CMD-line engine.
package sd_cmd_pkg;
  localparam logic [1:0] RESP_NONE      = 2'b00;
  localparam logic [1:0] RESP_R48       = 2'b01;
  localparam logic [1:0] RESP_R136      = 2'b10;
  localparam logic [1:0] RESP_R48_NOCRC = 2'b11;

  localparam int CMD_LEN  = 48;
  localparam int R48_LEN  = 48;
  localparam int R136_LEN = 136;
  localparam int CRC_LEN  = 40;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [2:0] {S_IDLE, S_TX, S_RX_WAIT, S_RX, S_GAP} state_e;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    return {crc[5:0], 1'b0} ^ ((b ^ crc[6]) ? CRC7_POLY : 7'h00);
  endfunction
endpackage

// File: rtl/sd_cmd_phy_if.sv
// Command issue / status bundle between the register block (master) and the CMD engine (slave).
interface sd_cmd_phy_if;
  logic         start;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   resp_type;
  logic         busy;
  logic         done;
  logic [127:0] resp;
  logic [5:0]   resp_index;
  logic         err_timeout;
  logic         err_crc;
  logic         err_index;
  logic         err_end;

  modport master (output start, cmd_index, cmd_arg, resp_type,
                  input  busy, done, resp, resp_index, err_timeout, err_crc, err_index, err_end);
  modport slave  (input  start, cmd_index, cmd_arg, resp_type,
                  output busy, done, resp, resp_index, err_timeout, err_crc, err_index, err_end);
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1), MSB first, init 0.
module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic       sd_clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc_out
);
  always_ff @(posedge sd_clock)
    if (!reset || clear) crc_out <= '0;
    else if (enable)     crc_out <= crc7_step(crc_out, bit_in);
endmodule

// File: rtl/sd_cmd_phy.sv
// SD CMD-line engine: shifts out a CRC7-protected command, captures and checks the card response.
module sd_cmd_phy
  import sd_cmd_pkg::*;
#(
  parameter int NCR_TIMEOUT = 64,
  parameter int NCC_GAP     = 8
) (
  input  logic         sd_clock,
  input  logic         reset,
  sd_cmd_phy_if.slave  bus,
  input  logic         cmd_pin_in,
  output logic         cmd_pin_out,
  output logic         cmd_pin_oe
);
  localparam int WW = $clog2(NCR_TIMEOUT + 1);
  localparam int GW = $clog2(NCC_GAP);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(NCR_TIMEOUT);
  localparam logic [GW-1:0] GAP_LAST  = GW'(NCC_GAP - 1);
  localparam logic [GW-1:0] GAP_DONE  = GW'(NCC_GAP - 2);
  localparam logic [5:0]    TX_LAST   = 6'(CMD_LEN - 1);
  localparam logic [5:0]    TX_CRC    = 6'(CRC_LEN - 1);
  localparam logic [7:0]    RX_CRC    = 8'(CRC_LEN);

  state_e        state;
  logic [5:0]    idx_q;
  logic [1:0]    type_q;
  logic [46:0]   tx_sr;
  logic [5:0]    tx_cnt;
  logic [WW-1:0] wait_cnt;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    rx_cnt;
  logic [133:0]  rx_sr;
  logic [134:0]  rx_frame;
  logic [6:0]    crc_tx, crc_rx;
  logic [7:0]    rx_last_cnt;
  logic          rx_last;
  logic          unused_bits;

  logic         busy, done, err_timeout, err_crc, err_index, err_end;
  logic [127:0] resp;
  logic [5:0]   resp_index;

  // rx_frame[k] is frame bit k on the edge that samples the end bit
  assign rx_frame    = {rx_sr, cmd_pin_in};
  assign rx_last_cnt = (type_q == RESP_R136) ? 8'(R136_LEN - 1) : 8'(R48_LEN - 1);
  assign rx_last     = (state == S_RX) && (rx_cnt == rx_last_cnt);
  assign unused_bits = ^rx_frame[133:128];

  // The leading 0 (start bit) leaves a zero CRC unchanged, so clearing on that bit absorbs it.
  sd_crc7 u_crc_tx (
    .sd_clock (sd_clock), .reset (reset),
    .clear    (state == S_IDLE && bus.start),
    .enable   (state == S_TX && tx_cnt < TX_CRC),
    .bit_in   (tx_sr[46]),
    .crc_out  (crc_tx)
  );

  sd_crc7 u_crc_rx (
    .sd_clock (sd_clock), .reset (reset),
    .clear    (state == S_RX_WAIT && !cmd_pin_in),
    .enable   (state == S_RX && rx_cnt < RX_CRC),
    .bit_in   (cmd_pin_in),
    .crc_out  (crc_rx)
  );

  always_ff @(posedge sd_clock) begin
    if (!reset) begin
      state       <= S_IDLE;
      idx_q       <= '0;
      type_q      <= RESP_NONE;
      tx_sr       <= '0;
      tx_cnt      <= '0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      rx_cnt      <= '0;
      rx_sr       <= '0;
      cmd_pin_out <= 1'b1;
      cmd_pin_oe  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      resp        <= '0;
      resp_index  <= '0;
      err_timeout <= 1'b0;
      err_crc     <= 1'b0;
      err_index   <= 1'b0;
      err_end     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          idx_q       <= bus.cmd_index;
          type_q      <= bus.resp_type;
          // bits after the leading 0; CRC slot is patched in at bit 40
          tx_sr       <= {1'b1, bus.cmd_index, bus.cmd_arg, 8'h01};
          tx_cnt      <= '0;
          cmd_pin_out <= 1'b0;
          cmd_pin_oe  <= 1'b1;
          busy        <= 1'b1;
          resp        <= '0;
          resp_index  <= '0;
          err_timeout <= 1'b0;
          err_crc     <= 1'b0;
          err_index   <= 1'b0;
          err_end     <= 1'b0;
          state       <= S_TX;
        end
        S_TX: if (tx_cnt == TX_LAST) begin
          cmd_pin_oe  <= 1'b0;
          cmd_pin_out <= 1'b1;
          wait_cnt    <= WW'(1);
          gap_cnt     <= '0;
          state       <= (type_q == RESP_NONE) ? S_GAP : S_RX_WAIT;
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
          if (tx_cnt == TX_CRC) begin
            cmd_pin_out <= crc_tx[6];
            tx_sr       <= {crc_tx[5:0], 1'b1, 40'h0};
          end else begin
            cmd_pin_out <= tx_sr[46];
            tx_sr       <= {tx_sr[45:0], 1'b0};
          end
        end
        S_RX_WAIT: if (!cmd_pin_in) begin
          rx_sr  <= '0;
          rx_cnt <= 8'd1;
          state  <= S_RX;
        end else if (wait_cnt == WAIT_MAX) begin
          err_timeout <= 1'b1;
          gap_cnt     <= '0;
          state       <= S_GAP;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        S_RX: begin
          rx_sr <= rx_frame[133:0];
          if (rx_last) begin
            if (type_q == RESP_R136) begin
              resp    <= {8'h00, rx_frame[127:8]};
              err_end <= rx_frame[134] | ~rx_frame[0];
            end else begin
              resp       <= {96'h0, rx_frame[39:8]};
              resp_index <= rx_frame[45:40];
              err_end    <= rx_frame[46] | ~rx_frame[0];
              if (type_q == RESP_R48) begin
                err_crc   <= (crc_rx != rx_frame[7:1]);
                err_index <= (rx_frame[45:40] != idx_q);
              end
            end
            gap_cnt <= '0;
            state   <= S_GAP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_GAP: if (gap_cnt == GAP_LAST) begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
          done    <= (gap_cnt == GAP_DONE);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.resp        = resp;
  assign bus.resp_index  = resp_index;
  assign bus.err_timeout = err_timeout;
  assign bus.err_crc     = err_crc;
  assign bus.err_index   = err_index;
  assign bus.err_end     = err_end;
endmodule
